// File: rtl/mem_stage_pkg.sv
// Shared widths, stall-vector positions and bus layouts for the memory-access stage.
// Mirrors the global defines so the stage and its sub-module agree on field positions.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;
  localparam int LOAD_W       = 5;
  localparam int STALL_W      = 6;

  localparam int  STALL_MEM = 3;
  localparam int  STALL_WB  = 4;
  localparam logic STOP     = 1'b1;
  localparam logic NO_STOP  = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lw;
  } load_flags_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Little-endian load alignment: picks the addressed byte/half of the SRAM word and extends it.
// With no sub-word flag set the whole word passes through, which covers lw.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic        lb,
  input  logic        lbu,
  input  logic        lh,
  input  logic        lhu,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
  end

  // Misaligned halfword addresses silently use the half selected by off[1].
  assign half_sel = off[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    load_data = raw;
    if (lb)
      load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (lbu)
      load_data = {24'd0, byte_sel};
    else if (lh)
      load_data = {{16{half_sel[15]}}, half_sel};
    else if (lhu)
      load_data = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, stall-safe SRAM read-data hold, load alignment,
// and packing of the MEM->WB and MEM->ID forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EX_TO_MEM_W = EX_TO_MEM_WD,
  parameter int MEM_TO_WB_W = MEM_TO_WB_WD,
  parameter int MEM_TO_RF_W = MEM_TO_RF_WD,
  parameter int LOAD_WD     = LOAD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
  input  logic [LOAD_WD-1:0]     ex_load_bus,
  input  logic [31:0]            data_sram_rdata,
  output logic [MEM_TO_WB_W-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_W-1:0] mem_to_rf_bus,
  output logic                   mem_is_load
);

  ex_to_mem_t  ex_r;
  load_flags_t load_r;
  logic        first_cyc;
  logic [31:0] rdata_buf;
  logic [31:0] raw;
  logic [31:0] load_data;
  logic [31:0] mem_result;
  logic        unused_ok;

  // A bubble is inserted when MEM holds but WB keeps draining; first_cyc marks any fresh entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r      <= '0;
      load_r    <= '0;
      first_cyc <= 1'b0;
    end else if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
      ex_r      <= '0;
      load_r    <= '0;
      first_cyc <= 1'b1;
    end else if (stall[STALL_MEM] == NO_STOP) begin
      ex_r      <= ex_to_mem_bus;
      load_r    <= ex_load_bus;
      first_cyc <= 1'b1;
    end else begin
      first_cyc <= 1'b0;
    end
  end

  // The SRAM only presents read data for one cycle, so a stalled entry keeps its own copy.
  always_ff @(posedge clk) begin
    if (rst)
      rdata_buf <= '0;
    else if (first_cyc && stall[STALL_MEM] == STOP)
      rdata_buf <= data_sram_rdata;
  end

  assign raw = first_cyc ? data_sram_rdata : rdata_buf;

  load_ext u_load_ext (
    .raw       (raw),
    .off       (ex_r.ex_result[1:0]),
    .lb        (load_r.lb),
    .lbu       (load_r.lbu),
    .lh        (load_r.lh),
    .lhu       (load_r.lhu),
    .load_data (load_data)
  );

  assign mem_result    = ex_r.sel_rf_res ? load_data : ex_r.ex_result;
  assign mem_to_wb_bus = {ex_r.pc, ex_r.rf_we, ex_r.rf_waddr, mem_result};
  assign mem_to_rf_bus = {ex_r.rf_we, ex_r.rf_waddr, mem_result};
  assign mem_is_load   = ex_r.ram_en & ~|ex_r.ram_wen;

  assign unused_ok = ^{stall[5], stall[2:0], load_r.lw};

endmodule
